// File: rtl/spi_reg_slave.sv
`default_nettype none
// ============================================================================
// Module      : spi_reg_slave
// Description : Oversampled SPI slave (all CPOL/CPHA modes) fronting a bank of
//               NUM_REGS registers; command frame then data frame per ss window.
//               Define SPI_AUTOINC_EN for burst access with address auto-increment.
// Revision    : 1.0 - initial release
// ============================================================================
module spi_reg_slave #(
    parameter int  DATA_W      = 8,
    parameter int  NUM_REGS    = 4,
    parameter int  SYNC_STAGES = 2,
    localparam int ADDR_W      = $clog2(NUM_REGS)
) (
    input  logic                       sys_clk,
    input  logic                       rst,
    input  logic                       ss,
    input  logic                       sclk,
    input  logic                       mosi,
    input  logic                       cpol,
    input  logic                       cpha,
    output logic                       miso,
    output logic [NUM_REGS*DATA_W-1:0] regs,
    output logic                       wr_strobe,
    output logic [ADDR_W-1:0]          wr_addr,
    output logic                       busy,
    output logic                       frame_err
);

    localparam int                c_cnt_w    = $clog2(DATA_W + 1);
    localparam logic [c_cnt_w-1:0] c_last    = c_cnt_w'(DATA_W - 1);
    localparam logic [ADDR_W:0]   c_num_regs = (ADDR_W + 1)'(NUM_REGS);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CMD  = 2'd1,
        DATA = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t                 r_state;
    logic [SYNC_STAGES-1:0] r_ss_sync;
    logic [SYNC_STAGES-1:0] r_sclk_sync;
    logic [SYNC_STAGES-1:0] r_mosi_sync;
    logic                   r_ss_d;
    logic                   r_sclk_d;
    logic                   r_cpol;
    logic                   r_cpha;
    logic [c_cnt_w-1:0]     r_cnt;
    logic [DATA_W-2:0]      r_rx;
    logic [DATA_W-1:0]      r_tx;
    logic                   r_is_write;
    logic [ADDR_W-1:0]      r_addr;

    logic                   w_ss_s;
    logic                   w_sclk_s;
    logic                   w_mosi_s;
    logic                   w_ss_rise;
    logic                   w_ss_fall;
    logic                   w_sclk_edge;
    logic                   w_lead;
    logic                   w_trail;
    logic                   w_sample;
    logic                   w_shift;
    logic                   w_last;
    logic [DATA_W-1:0]      w_word;
    logic [ADDR_W-1:0]      w_cmd_addr;
    logic                   w_cmd_in_range;
    logic                   w_addr_in_range;
    logic                   w_completing;

    assign w_ss_s          = r_ss_sync[SYNC_STAGES-1];
    assign w_sclk_s        = r_sclk_sync[SYNC_STAGES-1];
    assign w_mosi_s        = r_mosi_sync[SYNC_STAGES-1];
    assign w_ss_rise       = w_ss_s & ~r_ss_d;
    assign w_ss_fall       = ~w_ss_s & r_ss_d;
    // Leading edge moves sclk away from its idle level, trailing edge returns it.
    assign w_sclk_edge     = w_sclk_s ^ r_sclk_d;
    assign w_lead          = w_sclk_edge & (w_sclk_s ^ r_cpol);
    assign w_trail         = w_sclk_edge & ~(w_sclk_s ^ r_cpol);
    assign w_sample        = r_cpha ? w_trail : w_lead;
    assign w_shift         = r_cpha ? w_lead : w_trail;
    assign w_last          = (r_cnt == c_last);
    assign w_word          = {r_rx, w_mosi_s};
    assign w_cmd_addr      = w_word[ADDR_W-1:0];
    assign w_cmd_in_range  = ({1'b0, w_cmd_addr} < c_num_regs);
    assign w_addr_in_range = ({1'b0, r_addr} < c_num_regs);
    assign w_completing    = (r_state == DATA) && w_sample && w_last;

`ifdef SPI_AUTOINC_EN
    localparam logic [ADDR_W:0] c_max_addr = (ADDR_W + 1)'(NUM_REGS - 1);
    logic [ADDR_W-1:0] w_next_addr;
    assign w_next_addr = ({1'b0, r_addr} >= c_max_addr) ? '0 : r_addr + ADDR_W'(1);
`endif

    assign miso = (r_state == DATA) && !r_is_write && r_tx[DATA_W-1];
    assign busy = (r_state != IDLE);

    always_ff @(posedge sys_clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_ss_sync   <= '0;
            r_sclk_sync <= '0;
            r_mosi_sync <= '0;
            r_ss_d      <= 1'b0;
            r_sclk_d    <= 1'b0;
            r_cpol      <= 1'b0;
            r_cpha      <= 1'b0;
            r_cnt       <= '0;
            r_rx        <= '0;
            r_tx        <= '0;
            r_is_write  <= 1'b0;
            r_addr      <= '0;
            regs        <= '0;
            wr_strobe   <= 1'b0;
            wr_addr     <= '0;
            frame_err   <= 1'b0;
        end else begin
            r_ss_sync   <= {r_ss_sync[SYNC_STAGES-2:0], ss};
            r_sclk_sync <= {r_sclk_sync[SYNC_STAGES-2:0], sclk};
            r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], mosi};
            r_ss_d      <= w_ss_s;
            r_sclk_d    <= w_sclk_s;
            wr_strobe   <= 1'b0;
            frame_err   <= 1'b0;

            case (r_state)
                IDLE: begin
                    if (w_ss_rise) begin
                        r_state <= CMD;
                        r_cnt   <= '0;
                        r_cpol  <= cpol;
                        r_cpha  <= cpha;
                    end
                end
                CMD: begin
                    if (w_sample) begin
                        r_rx <= w_word[DATA_W-2:0];
                        if (w_last) begin
                            r_cnt      <= '0;
                            r_state    <= DATA;
                            r_is_write <= w_word[DATA_W-1];
                            r_addr     <= w_cmd_addr;
                            r_tx       <= (!w_word[DATA_W-1] && w_cmd_in_range) ?
                                          regs[w_cmd_addr*DATA_W +: DATA_W] : '0;
                        end else begin
                            r_cnt <= r_cnt + c_cnt_w'(1);
                        end
                    end
                end
                DATA: begin
                    // The shift edge preceding a frame's first sample would drop the MSB.
                    if (w_shift && (r_cnt != '0)) begin
                        r_tx <= {r_tx[DATA_W-2:0], 1'b0};
                    end
                    if (w_sample) begin
                        r_rx <= w_word[DATA_W-2:0];
                        if (w_last) begin
                            r_cnt <= '0;
                            if (r_is_write && w_addr_in_range) begin
                                regs[r_addr*DATA_W +: DATA_W] <= w_word;
                                wr_strobe <= 1'b1;
                                wr_addr   <= r_addr;
                            end
`ifdef SPI_AUTOINC_EN
                            r_addr <= w_next_addr;
                            if (!r_is_write) begin
                                r_tx <= regs[w_next_addr*DATA_W +: DATA_W];
                            end
`else
                            r_state <= DONE;
`endif
                        end else begin
                            r_cnt <= r_cnt + c_cnt_w'(1);
                        end
                    end
                end
                DONE: begin
                end
                default: r_state <= IDLE;
            endcase

            if (w_ss_fall) begin
                r_state <= IDLE;
                r_cnt   <= '0;
                if (((r_state == CMD) || (r_state == DATA)) && (r_cnt != '0) && !w_completing) begin
                    frame_err <= 1'b1;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_spi_reg_slave.sv
`default_nettype none
// ============================================================================
// Module      : tb_spi_reg_slave
// Description : Scoreboard bench for spi_reg_slave (4-register and 3-register builds).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_spi_reg_slave;

    localparam int HP = 8;

    logic        sys_clk = 1'b0;
    logic        rst     = 1'b1;
    logic        ss_a    = 1'b0;
    logic        ss_b    = 1'b0;
    logic        sclk    = 1'b0;
    logic        mosi    = 1'b0;
    logic        cpol    = 1'b0;
    logic        cpha    = 1'b0;
    logic        miso_a, miso_b;
    logic [31:0] regs_a;
    logic [23:0] regs_b;
    logic        wr_strobe_a, wr_strobe_b;
    logic [1:0]  wr_addr_a, wr_addr_b;
    logic        busy_a, busy_b;
    logic        frame_err_a, frame_err_b;

    typedef struct {
        logic [1:0] addr;
        logic [7:0] data;
    } wr_t;

    wr_t        exp_wr_a[$];
    wr_t        exp_wr_b[$];
    int         exp_err_a[$];
    logic [7:0] exp_rd[$];
    logic [7:0] got_rd[$];
    int         n_vec = 0;
    int         n_err = 0;
    logic [15:0] rx;

    always #5 sys_clk = ~sys_clk;

    spi_reg_slave dut_a (
        .sys_clk   (sys_clk),
        .rst       (rst),
        .ss        (ss_a),
        .sclk      (sclk),
        .mosi      (mosi),
        .cpol      (cpol),
        .cpha      (cpha),
        .miso      (miso_a),
        .regs      (regs_a),
        .wr_strobe (wr_strobe_a),
        .wr_addr   (wr_addr_a),
        .busy      (busy_a),
        .frame_err (frame_err_a)
    );

    spi_reg_slave #(.NUM_REGS(3)) dut_b (
        .sys_clk   (sys_clk),
        .rst       (rst),
        .ss        (ss_b),
        .sclk      (sclk),
        .mosi      (mosi),
        .cpol      (cpol),
        .cpha      (cpha),
        .miso      (miso_b),
        .regs      (regs_b),
        .wr_strobe (wr_strobe_b),
        .wr_addr   (wr_addr_b),
        .busy      (busy_b),
        .frame_err (frame_err_b)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic wait_clks(input int n);
        repeat (n) @(posedge sys_clk);
        #1;
    endtask

    task automatic xfer(input logic sel_b, input logic [15:0] tx, input int nbits,
                        output logic [15:0] rd);
        rd = '0;
        for (int i = nbits - 1; i >= 0; i--) begin
            mosi = tx[i];
            if (!cpha) begin
                wait_clks(HP);
                rd   = {rd[14:0], (sel_b ? miso_b : miso_a)};
                sclk = ~cpol;
                wait_clks(HP);
                sclk = cpol;
            end else begin
                sclk = ~cpol;
                wait_clks(HP);
                rd   = {rd[14:0], (sel_b ? miso_b : miso_a)};
                sclk = cpol;
                wait_clks(HP);
            end
        end
    endtask

    task automatic begin_txn(input logic sel_b, input logic pol, input logic pha);
        cpol = pol;
        cpha = pha;
        sclk = pol;
        wait_clks(HP);
        if (sel_b) ss_b = 1'b1;
        else       ss_a = 1'b1;
        wait_clks(HP);
    endtask

    task automatic end_txn;
        wait_clks(HP);
        ss_a = 1'b0;
        ss_b = 1'b0;
        wait_clks(2 * HP);
    endtask

    // Scoreboard monitor: consumes expectations whenever a DUT output event appears.
    initial begin
        wr_t        w;
        logic [7:0] g;
        forever begin
            @(negedge sys_clk);
            if (wr_strobe_a) begin
                if (exp_wr_a.size() == 0) begin
                    n_vec++; n_err++;
                    $display("FAIL wr_a_unexpected: wr_addr=%0d, expected no strobe", wr_addr_a);
                end else begin
                    w = exp_wr_a.pop_front();
                    check("wr_a_addr", 32'(wr_addr_a), 32'(w.addr));
                    check("wr_a_data", 32'(regs_a[w.addr*8 +: 8]), 32'(w.data));
                end
            end
            if (wr_strobe_b) begin
                if (exp_wr_b.size() == 0) begin
                    n_vec++; n_err++;
                    $display("FAIL wr_b_unexpected: wr_addr=%0d, expected no strobe", wr_addr_b);
                end else begin
                    w = exp_wr_b.pop_front();
                    check("wr_b_addr", 32'(wr_addr_b), 32'(w.addr));
                    check("wr_b_data", 32'(regs_b[w.addr*8 +: 8]), 32'(w.data));
                end
            end
            if (frame_err_a) begin
                if (exp_err_a.size() == 0) begin
                    n_vec++; n_err++;
                    $display("FAIL frame_err_a_unexpected: got 1, expected 0");
                end else begin
                    check("frame_err_a", 32'(frame_err_a), 32'(exp_err_a.pop_front()));
                end
            end
            if (frame_err_b) begin
                n_vec++; n_err++;
                $display("FAIL frame_err_b_unexpected: got 1, expected 0");
            end
            if (got_rd.size() != 0) begin
                g = got_rd.pop_front();
                if (exp_rd.size() == 0) begin
                    n_vec++; n_err++;
                    $display("FAIL rd_unexpected: got %h, expected nothing", g);
                end else begin
                    check("rd_data", 32'(g), 32'(exp_rd.pop_front()));
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err + 1);
        $fatal(1);
    end

    initial begin
        // Reset state
        wait_clks(4);
        check("rst_regs_a", regs_a, 32'h0);
        check("rst_busy_a", 32'(busy_a), 32'h0);
        check("rst_miso_a", 32'(miso_a), 32'h0);
        check("rst_strobe_a", 32'(wr_strobe_a), 32'h0);
        rst = 1'b0;
        wait_clks(2 * HP);

        // Write 0xAA to reg 1, mode 0
        exp_wr_a.push_back('{addr: 2'd1, data: 8'hAA});
        begin_txn(1'b0, 1'b0, 1'b0);
        xfer(1'b0, 16'h81, 8, rx);
        xfer(1'b0, 16'hAA, 8, rx);
        end_txn();
        check("after_wr_regs_a", regs_a, 32'h0000AA00);

        // Read reg 1, mode 3
        exp_rd.push_back(8'hAA);
        begin_txn(1'b0, 1'b1, 1'b1);
        xfer(1'b0, 16'h01, 8, rx);
        xfer(1'b0, 16'h00, 8, rx);
        got_rd.push_back(rx[7:0]);
        end_txn();

        // Aborted write to reg 2 after 5 data bits
        exp_err_a.push_back(1);
        begin_txn(1'b0, 1'b0, 1'b0);
        xfer(1'b0, 16'h82, 8, rx);
        xfer(1'b0, 16'h16, 5, rx);
        wait_clks(HP);
        ss_a = 1'b0;
        wait_clks(4);
        check("abort_busy_a", 32'(busy_a), 32'h0);
        check("abort_reg2", 32'(regs_a[23:16]), 32'h0);
        wait_clks(2 * HP);

        // 3-register build: in-range write (mode 1), out-of-range write, two reads (mode 2)
        exp_wr_b.push_back('{addr: 2'd2, data: 8'h5A});
        begin_txn(1'b1, 1'b0, 1'b1);
        xfer(1'b1, 16'h82, 8, rx);
        xfer(1'b1, 16'h5A, 8, rx);
        end_txn();
        begin_txn(1'b1, 1'b0, 1'b1);
        xfer(1'b1, 16'h83, 8, rx);
        xfer(1'b1, 16'h55, 8, rx);
        end_txn();
        check("oor_regs_b", 32'(regs_b), 32'h005A0000);
        exp_rd.push_back(8'h5A);
        begin_txn(1'b1, 1'b1, 1'b0);
        xfer(1'b1, 16'h02, 8, rx);
        xfer(1'b1, 16'h00, 8, rx);
        got_rd.push_back(rx[7:0]);
        end_txn();
        exp_rd.push_back(8'h00);
        begin_txn(1'b1, 1'b1, 1'b0);
        xfer(1'b1, 16'h03, 8, rx);
        xfer(1'b1, 16'hFF, 8, rx);
        got_rd.push_back(rx[7:0]);
        end_txn();

        // Reset after 3 command bits
        begin_txn(1'b0, 1'b0, 1'b0);
        xfer(1'b0, 16'h0004, 3, rx);
        wait_clks(HP);
        rst = 1'b1;
        wait_clks(1);
        rst = 1'b0;
        check("midrst_regs_a", regs_a, 32'h0);
        check("midrst_regs_b", 32'(regs_b), 32'h0);
        check("midrst_miso_a", 32'(miso_a), 32'h0);
        check("midrst_busy_a", 32'(busy_a), 32'h0);
        ss_a = 1'b0;
        wait_clks(2 * HP);

        // Full write after reset
        exp_wr_a.push_back('{addr: 2'd0, data: 8'h11});
        begin_txn(1'b0, 1'b0, 1'b0);
        xfer(1'b0, 16'h80, 8, rx);
        xfer(1'b0, 16'h11, 8, rx);
        end_txn();

        // Burst: cmd 0x83 followed by two data words
        exp_wr_a.push_back('{addr: 2'd3, data: 8'h01});
`ifdef SPI_AUTOINC_EN
        exp_wr_a.push_back('{addr: 2'd0, data: 8'h02});
`endif
        begin_txn(1'b0, 1'b0, 1'b0);
        xfer(1'b0, 16'h83, 8, rx);
        xfer(1'b0, 16'h01, 8, rx);
        xfer(1'b0, 16'h02, 8, rx);
        end_txn();

`ifdef SPI_AUTOINC_EN
        check("final_regs_a", regs_a, 32'h01000002);
`else
        check("final_regs_a", regs_a, 32'h01000011);
`endif
        check("final_busy_a", 32'(busy_a), 32'h0);
        wait_clks(4);
        check("pending_wr_a", 32'(exp_wr_a.size()), 32'h0);
        check("pending_wr_b", 32'(exp_wr_b.size()), 32'h0);
        check("pending_err_a", 32'(exp_err_a.size()), 32'h0);
        check("pending_rd", 32'(exp_rd.size()), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
